// File: rtl/traffic_pkg.sv
// +----------------------------------------------------------------------------+
// | traffic_pkg: light codes and loop-detector state encodings shared by the    |
// | country-road sensor and the highway/country controller.    Rev 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

package traffic_pkg;

   typedef enum logic [1:0] {
      RED    = 2'b00,
      YELLOW = 2'b01,
      GREEN  = 2'b10
   } light_t;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      QUAL_ON  = 2'b01,
      PRESENT  = 2'b10,
      QUAL_OFF = 2'b11
   } det_state_t;

   localparam int QCNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/country_queue_sensor_loop_detector.sv
// +----------------------------------------------------------------------------+
// | loop_detector: 2-flop synchronizer plus presence FSM; one pulse per car.    |
// | Optional debounce via SENSOR_DEBOUNCE_EN.                  Rev 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module loop_detector
   import traffic_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic raw,
   output logic pulse
);

   logic       s1;
   logic       s2;
   det_state_t state;

   if (DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_deb_range_check
      $error("loop_detector: DEB_CYCLES must be within 2..255");
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

`ifdef SENSOR_DEBOUNCE_EN
   logic [QCNT_W-1:0] qcnt;
   logic              qual_done;

   // qcnt already counts the sample that opened the qualification window.
   assign qual_done = (qcnt == QCNT_W'(DEB_CYCLES - 1));
   assign pulse     = (state == QUAL_ON) && s2 && qual_done;

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= IDLE;
         qcnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (s2) begin
                  state <= QUAL_ON;
                  qcnt  <= QCNT_W'(1);
               end
            end
            QUAL_ON: begin
               if (!s2) begin
                  state <= IDLE;
                  qcnt  <= '0;
               end else if (qual_done) begin
                  state <= PRESENT;
                  qcnt  <= '0;
               end else begin
                  qcnt <= qcnt + 1'b1;
               end
            end
            PRESENT: begin
               if (!s2) begin
                  state <= QUAL_OFF;
                  qcnt  <= QCNT_W'(1);
               end
            end
            QUAL_OFF: begin
               if (s2) begin
                  state <= PRESENT;
                  qcnt  <= '0;
               end else if (qual_done) begin
                  state <= IDLE;
                  qcnt  <= '0;
               end else begin
                  qcnt <= qcnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               qcnt  <= '0;
            end
         endcase
      end
   end
`else
   // Pulse is a decode of the IDLE->PRESENT transition, so the counter moves on the same edge.
   assign pulse = (state == IDLE) && s2;

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (s2)  state <= PRESENT;
            PRESENT: if (!s2) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/country_queue_sensor.sv
// +----------------------------------------------------------------------------+
// | country_queue_sensor: country-road queue counter feeding controller x.      |
// | Debounce option: SENSOR_DEBOUNCE_EN.                       Rev 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module country_queue_sensor
   import traffic_pkg::*;
#(
   parameter int CNT_W      = 4,
   parameter int DEB_CYCLES = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             arr_raw,
   input  logic             dep_raw,
   input  logic [1:0]       cntry,
   output logic             x,
   output logic [CNT_W-1:0] count,
   output logic             ovf,
   output logic             err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic arr_p;
   logic dep_p;

   loop_detector #(.DEB_CYCLES(DEB_CYCLES)) u_arr (
      .clk   (clk),
      .clr   (clr),
      .raw   (arr_raw),
      .pulse (arr_p)
   );

   loop_detector #(.DEB_CYCLES(DEB_CYCLES)) u_dep (
      .clk   (clk),
      .clr   (clr),
      .raw   (dep_raw),
      .pulse (dep_p)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
         ovf   <= 1'b0;
         err   <= 1'b0;
      end else begin
         // Leaving on red is a fault even when it cancels against an arrival.
         if (dep_p && (cntry == RED)) err <= 1'b1;
         case ({arr_p, dep_p})
            2'b10: begin
               if (count == CNT_MAX) ovf   <= 1'b1;
               else                  count <= count + 1'b1;
            end
            2'b01: begin
               if (count == '0) err   <= 1'b1;
               else             count <= count - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign x = (count != '0);

endmodule

`default_nettype wire

// File: tb/tb_country_queue_sensor.sv
// +----------------------------------------------------------------------------+
// | tb_country_queue_sensor: vector table plus scoreboard for the sensor.      |
// | Expectations follow SENSOR_DEBOUNCE_EN when defined.       Rev 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_country_queue_sensor;
   import traffic_pkg::*;

   localparam int CNT_W  = 2;
   localparam int DEB    = 4;
`ifdef SENSOR_DEBOUNCE_EN
   localparam int LAT    = DEB;
   localparam bit DEB_ON = 1'b1;
`else
   localparam int LAT    = 1;
   localparam bit DEB_ON = 1'b0;
`endif
   localparam int SETTLE = 2 * DEB + 6;

   logic             clk = 1'b0;
   logic             clr;
   logic             arr_raw;
   logic             dep_raw;
   logic [1:0]       cntry;
   logic             x;
   logic [CNT_W-1:0] count;
   logic             ovf;
   logic             err;

   always #5 clk = ~clk;

   country_queue_sensor #(.CNT_W(CNT_W), .DEB_CYCLES(DEB)) dut (
      .clk     (clk),
      .clr     (clr),
      .arr_raw (arr_raw),
      .dep_raw (dep_raw),
      .cntry   (cntry),
      .x       (x),
      .count   (count),
      .ovf     (ovf),
      .err     (err)
   );

   typedef struct {
      bit         pre_clr;
      bit         arr;
      bit         dep;
      logic [1:0] light;
      int         hold;
      int         exp_count;
      bit         exp_ovf;
      bit         exp_err;
   } vec_t;

   typedef struct {
      int count;
      bit ovf;
      bit err;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[12];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic check_val(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic push_exp(input int c, input bit o, input bit e);
      exp_t t;
      t.count = c;
      t.ovf   = o;
      t.err   = e;
      sb.push_back(t);
   endtask

   task automatic check_state(input string tag);
      exp_t t;
      if (sb.size() == 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got count %0d, expected an entry", tag, count);
      end else begin
         t = sb.pop_front();
         check_val({tag, " count"}, int'(count), t.count);
         check_val({tag, " x"},     int'(x),     int'(t.count != 0));
         check_val({tag, " ovf"},   int'(ovf),   int'(t.ovf));
         check_val({tag, " err"},   int'(err),   int'(t.err));
      end
   endtask

   task automatic do_clr(input int n);
      @(negedge clk);
      clr = 1'b1;
      repeat (n) @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic drive_event(input bit a, input bit d, input logic [1:0] l, input int hold);
      @(negedge clk);
      cntry   = l;
      arr_raw = a;
      dep_raw = d;
      repeat (hold) @(negedge clk);
      arr_raw = 1'b0;
      dep_raw = 1'b0;
      repeat (SETTLE) @(negedge clk);
   endtask

   initial begin
      clr     = 1'b1;
      arr_raw = 1'b1;
      dep_raw = 1'b0;
      cntry   = GREEN;

      vecs[0]  = '{1'b0, 1'b0, 1'b1, GREEN,  8, 0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, GREEN,  8, 0, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, GREEN,  8, 1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, GREEN,  8, 2, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, RED,    8, 1, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, GREEN,  8, 1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, GREEN,  8, 1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, GREEN,  8, 2, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, YELLOW, 8, 3, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, GREEN,  8, 3, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b1, GREEN,  8, 2, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b1, YELLOW, 8, 1, 1'b1, 1'b0};

      // Reset held with the arrival loop occupied.
      repeat (3) @(posedge clk);
      #1;
      push_exp(0, 1'b0, 1'b0);
      check_state("reset");
      @(negedge clk);
      clr = 1'b0;
      repeat (LAT + 4) @(negedge clk);
      push_exp(1, 1'b0, 1'b0);
      check_state("post_reset_arrival");
      arr_raw = 1'b0;
      repeat (SETTLE) @(negedge clk);

      // Exact arrival latency with a long dwell.
      do_clr(1);
      arr_raw = 1'b1;
      @(posedge clk);
      repeat (LAT) @(posedge clk);
      #1;
      push_exp(0, 1'b0, 1'b0);
      check_state("latency_early");
      @(posedge clk);
      #1;
      push_exp(1, 1'b0, 1'b0);
      check_state("latency_edge");
      repeat (20) @(negedge clk);
      arr_raw = 1'b0;
      repeat (SETTLE) @(negedge clk);
      push_exp(1, 1'b0, 1'b0);
      check_state("long_dwell");

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].pre_clr) do_clr(1);
         push_exp(vecs[i].exp_count, vecs[i].exp_ovf, vecs[i].exp_err);
         drive_event(vecs[i].arr, vecs[i].dep, vecs[i].light, vecs[i].hold);
         check_state($sformatf("vec%0d", i));
      end

      // Short glitch: filtered only when debounce is compiled in.
      do_clr(1);
      push_exp(DEB_ON ? 0 : 1, 1'b0, 1'b0);
      drive_event(1'b1, 1'b0, GREEN, 2);
      check_state("glitch");

      // Brief dropout mid-dwell: one car with debounce, two without.
      do_clr(1);
      push_exp(DEB_ON ? 1 : 2, 1'b0, 1'b0);
      @(negedge clk);
      arr_raw = 1'b1;
      repeat (8) @(negedge clk);
      arr_raw = 1'b0;
      repeat (2) @(negedge clk);
      arr_raw = 1'b1;
      repeat (8) @(negedge clk);
      arr_raw = 1'b0;
      repeat (SETTLE) @(negedge clk);
      check_state("dropout");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
